bus_xcvr_seq: RTL
=================

# bus_xcvr_seq

Sequencer that owns the direction (DIR) and enable (G_n) controls of an 8-bit 74245-style bus transceiver. Sits directly upstream of the transceiver: it accepts single-word read/write requests from the CPU-side logic, drives write data toward the transceiver A port, and captures read data from it. Direction reversal always passes through a disabled dead time, so the transceiver never drives against the bus.

## Interface
Parameters:
- WIDTH, 8, data width, matching the transceiver.
- TURN_CYC, 1, dead cycles with G_n high when DIR changes; range 1..15.
- HOLD_CYC, 2, cycles G_n is held low per transfer; range 1..15.

Ports:
- sysclk, in, 1, the single clock; all state changes on the rising edge.
- sysrst, in, 1, asynchronous, active-high reset.
- req, in, 1, transfer request; sampled only in IDLE.
- wr, in, 1, 1 = write (A→B, DIR=1), 0 = read (B→A, DIR=0); sampled with req.
- wdata, in, WIDTH, write data; sampled with req.
- ack, out, 1, one-cycle completion pulse.
- rdata, out, WIDTH, last captured read word.
- busy, out, 1, high in every state except IDLE.
- xcvr_dir, out, 1, to transceiver DIR.
- xcvr_g_n, out, 1, to transceiver G_n (active-low enable).
- xcvr_a_out, out, WIDTH, write data presented to A port.
- xcvr_a_in, in, WIDTH, A-port data during reads.

## Operation
- States: IDLE, TURN, XFER, DONE.
- IDLE: G_n=1. On req, latch wr and wdata. If latched wr equals current xcvr_dir, go to XFER; otherwise go to TURN.
- TURN: G_n=1. xcvr_dir takes the new value on entry. Stay TURN_CYC cycles, then go to XFER.
- XFER: G_n=0 for exactly HOLD_CYC cycles. On a write, xcvr_a_out = latched wdata. On a read, rdata loads xcvr_a_in on the rising edge that ends the last XFER cycle. Then go to DONE.
- DONE: G_n=1 and ack=1 for one cycle, then go to IDLE.
- xcvr_dir only changes on entry to TURN, and never in the same cycle G_n is low. It holds its value through IDLE.
- req outside IDLE is ignored. There is no queueing; the requester waits for busy=0.
- req in the DONE cycle is ignored. It is accepted no earlier than the following IDLE cycle.
- xcvr_a_out holds the last write data outside writes. It has no functional meaning then.
- Cycle counting: one 4-bit down-counter, loaded on entry to TURN/XFER with the count minus 1. The state is left when the counter reads 0.
- Reset values: state IDLE, ack=0, busy=0, xcvr_g_n=1, xcvr_dir=0, xcvr_a_out=0, rdata=0.
- Reset mid-operation: abort immediately to the reset values. No ack is issued and rdata is not updated.

## Timing
- Same-direction transfer, req seen in cycle n:
  - G_n low in cycles n+1 .. n+HOLD_CYC.
  - ack in cycle n+HOLD_CYC+1.
  - busy high in cycles n+1 .. n+HOLD_CYC+1.
- Direction change: add TURN_CYC cycles before XFER. ack arrives in cycle n+TURN_CYC+HOLD_CYC+1.
- Minimum back-to-back spacing: req accepted in the cycle after DONE. Period is HOLD_CYC+2 cycles, plus TURN_CYC when the direction alternates.
- rdata is valid in the ack cycle and stable until the next read completes.
- All outputs are registered. No combinational path from any input to any output.

## Configuration
- BUS_XCVR_PARITY_EN defined:
  - Adds output rdata_par (1 bit) = odd parity of the captured word, registered together with rdata (reset 0).
  - Adds input xcvr_par_in (1 bit), sampled with xcvr_a_in.
  - Adds output par_err (1 bit): pulses with ack when the computed parity differs from xcvr_par_in on a read.
- Undefined: these ports and logic are absent; all other behaviour is identical.

## Structure
- Package bus_xcvr_pkg holds:
  - the state enum (IDLE, TURN, XFER, DONE);
  - DIR_A2B=1'b1 and DIR_B2A=1'b0;
  - the counter width constant (4).
- One sub-module, bus_xcvr_cnt: a loadable 4-bit down-counter with a zero flag.

## Test plan
- Reset then idle: xcvr_g_n=1, xcvr_dir=0, ack=0, rdata=0 for 10 cycles.
- Read with default parameters and xcvr_a_in=8'hA5, req at cycle 5: G_n low in cycles 6–7, ack in cycle 8, rdata=8'hA5, no TURN state.
- Write of 8'h3C after the read: dir=0→1 at TURN entry (cycle 10, G_n=1), G_n low in cycles 11–12, xcvr_a_out=8'h3C, ack in cycle 13.
- req held high during busy, then write→read→write: exactly three acks. Dir never changes while G_n=0, and each change is preceded by TURN_CYC cycles of G_n=1.
- sysrst asserted in the second XFER cycle of a read: outputs at reset values immediately, no ack, rdata keeps its previous value of 0.
- With BUS_XCVR_PARITY_EN, read 8'h07 with xcvr_par_in=0: rdata_par=0 and par_err=0. Repeat with xcvr_par_in=1: par_err=1 in the ack cycle.

Source files
------------

// File: rtl/bus_xcvr_pkg.sv
// bus_xcvr_pkg: shared types and constants for the 74245-style transceiver
// sequencer (bus_xcvr_seq) and its cycle counter (bus_xcvr_cnt).
package bus_xcvr_pkg;

  // Width of the shared dead-time / hold-time down-counter.
  localparam int CNT_W = 4;

  // Transceiver DIR encodings.
  localparam logic DIR_A2B = 1'b1;  // write: A port drives B side
  localparam logic DIR_B2A = 1'b0;  // read: B side drives A port

  // Sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_TURN = 2'd1,
    ST_XFER = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Counter load value for a phase lasting cyc cycles. The phase ends in the
  // cycle where the counter reads zero.
  function automatic logic [CNT_W-1:0] cyc_to_load(input int cyc);
    return CNT_W'(cyc - 1);
  endfunction

endpackage

// File: rtl/bus_xcvr_seq_if.sv
// bus_xcvr_seq_if: CPU-side request/ack signals plus the transceiver control
// and data lines of bus_xcvr_seq. The parity lines exist only when
// BUS_XCVR_PARITY_EN is defined.
//
// Handshake: the requester raises req with wr/wdata valid. The sequencer
// samples them only in a cycle where busy=0. Once it has accepted a request,
// busy stays high until the transfer completes. ack is a single-cycle pulse
// in the final (DONE) cycle. rdata is valid from that ack cycle onward. There
// is no queueing, so a requester holding req waits for busy=0.
interface bus_xcvr_seq_if #(
  parameter int WIDTH = 8
);
  logic             req;
  logic             wr;
  logic [WIDTH-1:0] wdata;
  logic             ack;
  logic [WIDTH-1:0] rdata;
  logic             busy;
  logic             xcvr_dir;
  logic             xcvr_g_n;
  logic [WIDTH-1:0] xcvr_a_out;
  logic [WIDTH-1:0] xcvr_a_in;
`ifdef BUS_XCVR_PARITY_EN
  logic             rdata_par;
  logic             xcvr_par_in;
  logic             par_err;
`endif

  // Sequencer side.
  modport slave (
    input  req, wr, wdata, xcvr_a_in,
    output ack, rdata, busy, xcvr_dir, xcvr_g_n, xcvr_a_out
`ifdef BUS_XCVR_PARITY_EN
    , input xcvr_par_in
    , output rdata_par, par_err
`endif
  );

  // Requester / transceiver side.
  modport master (
    output req, wr, wdata, xcvr_a_in,
    input  ack, rdata, busy, xcvr_dir, xcvr_g_n, xcvr_a_out
`ifdef BUS_XCVR_PARITY_EN
    , output xcvr_par_in
    , input rdata_par, par_err
`endif
  );

endinterface

// File: rtl/bus_xcvr_cnt.sv
// bus_xcvr_cnt: loadable down-counter with a zero flag. It decrements every
// cycle until it reaches zero and then holds there. A load takes priority
// over the decrement.
module bus_xcvr_cnt
  import bus_xcvr_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: load, otherwise decrement and saturate at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/bus_xcvr_seq.sv
// bus_xcvr_seq: owns DIR and G_n of an 8-bit 74245-style transceiver. It
// runs one single-word read or write at a time. Every direction reversal
// passes through TURN_CYC dead cycles with G_n high, so the transceiver
// never drives against the bus. All outputs are registered.
// Optional feature macro: BUS_XCVR_PARITY_EN. It adds odd parity on
// captured read data and a parity-error pulse alongside ack.
module bus_xcvr_seq
  import bus_xcvr_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int TURN_CYC = 1,   // 1..15
  parameter int HOLD_CYC = 2    // 1..15
) (
  input  logic           sysclk,
  input  logic           sysrst,
  bus_xcvr_seq_if.slave  bus,
  output state_t         state_o  // current FSM state, for debug/checkers
);

  state_t           state_q;
  logic             wr_q;       // latched direction of the current transfer
  logic             dir_q;
  logic             g_n_q;
  logic             ack_q;
  logic             busy_q;
  logic [WIDTH-1:0] a_out_q;
  logic [WIDTH-1:0] rdata_q;
`ifdef BUS_XCVR_PARITY_EN
  logic             rdata_par_q;
  logic             par_err_q;
`endif

  logic             cnt_load;
  logic [CNT_W-1:0] cnt_load_val;
  logic             cnt_zero;

  // Counter load: on entry to TURN or XFER, with the phase length minus one.
  always_comb begin
    cnt_load     = 1'b0;
    cnt_load_val = cyc_to_load(HOLD_CYC);
    case (state_q)
      ST_IDLE: begin
        if (bus.req) begin
          cnt_load = 1'b1;
          if (bus.wr != dir_q) begin
            cnt_load_val = cyc_to_load(TURN_CYC);
          end
        end
      end
      ST_TURN: begin
        if (cnt_zero) begin
          cnt_load = 1'b1;
        end
      end
      default: begin
        cnt_load = 1'b0;
      end
    endcase
  end

  bus_xcvr_cnt u_cnt (
    .clk_i      (sysclk),
    .rst_i      (sysrst),
    .load_i     (cnt_load),
    .load_val_i (cnt_load_val),
    .zero_o     (cnt_zero)
  );

  // Sequencer FSM with registered outputs. DIR only moves on TURN entry,
  // while G_n is high. A reset mid-transfer drops everything at once.
  always_ff @(posedge sysclk or posedge sysrst) begin
    if (sysrst) begin
      state_q     <= ST_IDLE;
      wr_q        <= DIR_B2A;
      dir_q       <= DIR_B2A;
      g_n_q       <= 1'b1;
      ack_q       <= 1'b0;
      busy_q      <= 1'b0;
      a_out_q     <= '0;
      rdata_q     <= '0;
`ifdef BUS_XCVR_PARITY_EN
      rdata_par_q <= 1'b0;
      par_err_q   <= 1'b0;
`endif
    end else begin
      ack_q     <= 1'b0;
`ifdef BUS_XCVR_PARITY_EN
      par_err_q <= 1'b0;
`endif
      case (state_q)
        ST_IDLE: begin
          if (bus.req) begin
            wr_q   <= bus.wr;
            busy_q <= 1'b1;
            if (bus.wr == DIR_A2B) begin
              a_out_q <= bus.wdata;
            end
            if (bus.wr == dir_q) begin
              state_q <= ST_XFER;
              g_n_q   <= 1'b0;
            end else begin
              state_q <= ST_TURN;
              dir_q   <= bus.wr;
            end
          end
        end
        ST_TURN: begin
          if (cnt_zero) begin
            state_q <= ST_XFER;
            g_n_q   <= 1'b0;
          end
        end
        ST_XFER: begin
          if (cnt_zero) begin
            state_q <= ST_DONE;
            g_n_q   <= 1'b1;
            ack_q   <= 1'b1;
            if (wr_q == DIR_B2A) begin
              rdata_q     <= bus.xcvr_a_in;
`ifdef BUS_XCVR_PARITY_EN
              rdata_par_q <= ~^bus.xcvr_a_in;
              par_err_q   <= (~^bus.xcvr_a_in) != bus.xcvr_par_in;
`endif
            end
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.ack        = ack_q;
  assign bus.rdata      = rdata_q;
  assign bus.busy       = busy_q;
  assign bus.xcvr_dir   = dir_q;
  assign bus.xcvr_g_n   = g_n_q;
  assign bus.xcvr_a_out = a_out_q;
`ifdef BUS_XCVR_PARITY_EN
  assign bus.rdata_par  = rdata_par_q;
  assign bus.par_err    = par_err_q;
`endif
  assign state_o        = state_q;

endmodule
